// File: rtl/pam5_tx_shaper.sv
// rtl/pam5_tx_shaper.sv - PAM5 symbol FIFO with per-lane post-cursor pre-emphasis and saturating TX samples
module pam5_tx_shaper #(
    parameter int DEPTH = 4,
    parameter int GAIN  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [11:0] io_in_bits,
    input  logic [7:0]  io_postTap,
    output logic [7:0]  io_samples_0,
    output logic [7:0]  io_samples_1,
    output logic [7:0]  io_samples_2,
    output logic [7:0]  io_samples_3,
    output logic        io_valid,
    input  logic        io_out_ready,
    output logic [2:0]  io_count,
    output logic        io_symErr,
    input  logic        io_clrErr
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_W = 3'(DEPTH);

    logic [11:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [2:0]         count;
    logic               push;
    logic               pop;
    logic [11:0]        head;
    logic [3:0]         illegal;
    logic signed [2:0]  sym  [4];
    logic signed [7:0]  nxt  [4];
    logic signed [2:0]  prev [4];
    logic signed [7:0]  smp  [4];
    logic               sym_err;
    logic               valid_q;

    // Ready depends only on registered occupancy, so a full FIFO never accepts even while popping
    assign io_in_ready = (count < DEPTH_W);
    assign push        = io_in_valid && io_in_ready;
    assign pop         = (io_out_ready || !valid_q) && (count != 3'd0);
    assign head        = mem[rd_ptr];

    assign io_samples_0 = smp[0];
    assign io_samples_1 = smp[1];
    assign io_samples_2 = smp[2];
    assign io_samples_3 = smp[3];
    assign io_valid     = valid_q;
    assign io_count     = count;
    assign io_symErr    = sym_err;

    // Decode the head word: sanitize each symbol and form the saturated pre-emphasized sample
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [2:0]         raw;
            logic signed [15:0] acc;
            raw        = head[11-3*i -: 3];
            illegal[i] = (raw == 3'b011) || (raw == 3'b100) || (raw == 3'b101);
            sym[i]     = illegal[i] ? 3'sd0 : $signed(raw);
            acc        = 16'(sym[i]) * 16'(GAIN) + 16'($signed(io_postTap)) * 16'(prev[i]);
            if (acc > 16'sd127) begin
                nxt[i] = 8'sd127;
            end else if (acc < -16'sd128) begin
                nxt[i] = -8'sd128;
            end else begin
                nxt[i] = acc[7:0];
            end
        end
    end

    // Storage array is not reset; stale words are unreachable once the pointers clear
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= io_in_bits;
        end
    end

    // Pointers, occupancy, output register, lane history and sticky error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 3'd0;
            valid_q <= 1'b0;
            sym_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                smp[i]  <= 8'sd0;
                prev[i] <= 3'sd0;
            end
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                valid_q <= 1'b1;
                for (int i = 0; i < 4; i++) begin
                    smp[i]  <= nxt[i];
                    prev[i] <= sym[i];
                end
            end else if (io_out_ready) begin
                valid_q <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (pop && (illegal != 4'b0000)) begin
                sym_err <= 1'b1;
            end else if (io_clrErr) begin
                sym_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pam5_tx_shaper.sv
// tb/tb_pam5_tx_shaper.sv - self-checking bench for pam5_tx_shaper
module tb_pam5_tx_shaper;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [11:0] io_in_bits;
    logic [7:0]  io_postTap;
    logic [7:0]  io_samples_0, io_samples_1, io_samples_2, io_samples_3;
    logic        io_valid;
    logic        io_out_ready;
    logic [2:0]  io_count;
    logic        io_symErr;
    logic        io_clrErr;

    pam5_tx_shaper #(.DEPTH(4), .GAIN(32)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
        .io_postTap(io_postTap),
        .io_samples_0(io_samples_0), .io_samples_1(io_samples_1),
        .io_samples_2(io_samples_2), .io_samples_3(io_samples_3),
        .io_valid(io_valid), .io_out_ready(io_out_ready), .io_count(io_count),
        .io_symErr(io_symErr), .io_clrErr(io_clrErr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] smp;
        logic        err;
    } entry_t;

    entry_t      pend[$];
    logic [31:0] cur_smp;
    logic        mvalid;
    logic        merr;
    int          mprev[4];
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] sat8(input int v);
        if (v > 127) return 8'd127;
        if (v < -128) return 8'h80;
        return 8'(v);
    endfunction

    // Expected result of a word, computed in push order (load order equals push order)
    function automatic entry_t model_word(input logic [11:0] w);
        entry_t e;
        int tap;
        tap = int'($signed(io_postTap));
        e.err = 1'b0;
        e.smp = '0;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] raw;
            int s;
            raw = w[11-3*i -: 3];
            s = int'($signed(raw));
            if (s > 2 || s < -2) begin
                s = 0;
                e.err = 1'b1;
            end
            e.smp[31-8*i -: 8] = sat8(s * 32 + tap * mprev[i]);
            mprev[i] = s;
        end
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(io_count), 32'(pend.size()));
        chk({tag, ".ready"}, 32'(io_in_ready), 32'(pend.size() < 4));
        chk({tag, ".valid"}, 32'(io_valid), 32'(mvalid));
        chk({tag, ".symerr"}, 32'(io_symErr), 32'(merr));
        chk({tag, ".samples"}, {io_samples_0, io_samples_1, io_samples_2, io_samples_3}, cur_smp);
    endtask

    task automatic model_clear();
        pend.delete();
        cur_smp = '0;
        mvalid  = 1'b0;
        merr    = 1'b0;
        for (int i = 0; i < 4; i++) mprev[i] = 0;
    endtask

    // One clock: advance the model with the inputs currently driven, then compare after the edge
    task automatic tick(input string tag);
        bit push, pop, set;
        entry_t e;
        push = io_in_valid && (pend.size() < 4);
        pop  = (io_out_ready || !mvalid) && (pend.size() > 0);
        set  = 1'b0;
        if (pop) begin
            e = pend.pop_front();
            cur_smp = e.smp;
            mvalid  = 1'b1;
            set     = e.err;
        end else if (io_out_ready) begin
            mvalid = 1'b0;
        end
        if (push) pend.push_back(model_word(io_in_bits));
        merr = set ? 1'b1 : (io_clrErr ? 1'b0 : merr);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_clear();
        check_all({tag, ".async"});
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all({tag, ".held"});
    endtask

    logic [11:0] words6 [6];

    initial begin
        reset = 1'b1; io_in_valid = 0; io_in_bits = 0; io_postTap = 0;
        io_out_ready = 1; io_clrErr = 0;
        model_clear();
        #3;
        check_all("por");
        @(negedge clock);
        reset = 1'b0;

        // Basic mapping, no bypass, valid drops with nothing behind
        io_postTap = 8'd0; io_in_valid = 1; io_in_bits = 12'h47E;
        tick("basic.push");
        chk("basic.novalid", 32'(io_valid), 32'd0);
        io_in_valid = 0;
        tick("basic.load");
        chk("basic.smp", {io_samples_0, io_samples_1, io_samples_2, io_samples_3}, 32'h4020E0C0);
        tick("basic.drain");
        chk("basic.valid0", 32'(io_valid), 32'd0);

        // Positive post-tap saturation
        do_reset("r1");
        io_postTap = 8'd64; io_in_valid = 1; io_in_bits = 12'h492;
        tick("sat.p0");
        tick("sat.p1");
        io_in_valid = 0;
        chk("sat.first", {io_samples_0, io_samples_1, io_samples_2, io_samples_3}, 32'h40404040);
        tick("sat.l1");
        chk("sat.second", {io_samples_0, io_samples_1, io_samples_2, io_samples_3}, 32'h7F7F7F7F);

        // Negative post-tap
        do_reset("r2");
        io_postTap = 8'hF0; io_in_valid = 1; io_in_bits = 12'hDB6;
        tick("neg.p0");
        io_in_bits = 12'h492;
        tick("neg.p1");
        io_in_valid = 0;
        chk("neg.first", {io_samples_0, io_samples_1, io_samples_2, io_samples_3}, 32'hC0C0C0C0);
        tick("neg.l1");
        chk("neg.second", {io_samples_0, io_samples_1, io_samples_2, io_samples_3}, 32'h60606060);

        // Backpressure: fill, drop extra, drain in order
        do_reset("r3");
        io_postTap = 8'd0; io_out_ready = 0;
        words6[0] = 12'h001; words6[1] = 12'h008; words6[2] = 12'h040;
        words6[3] = 12'h200; words6[4] = 12'h049; words6[5] = 12'h492;
        for (int i = 0; i < 6; i++) begin
            io_in_valid = 1; io_in_bits = words6[i];
            tick("bp.fill");
        end
        io_in_valid = 0;
        chk("bp.count4", 32'(io_count), 32'd4);
        chk("bp.full", 32'(io_in_ready), 32'd0);
        chk("bp.valid", 32'(io_valid), 32'd1);
        io_out_ready = 1;
        for (int i = 0; i < 6; i++) tick("bp.drain");
        chk("bp.empty", 32'(io_count), 32'd0);

        // Illegal code, sticky flag, clear, and set beating clear
        do_reset("r4");
        io_in_valid = 1; io_in_bits = 12'h800;
        tick("err.push");
        io_in_valid = 0;
        tick("err.load");
        chk("err.lane0", 32'(io_samples_0), 32'd0);
        chk("err.flag", 32'(io_symErr), 32'd1);
        tick("err.hold");
        io_clrErr = 1;
        tick("err.clr");
        chk("err.cleared", 32'(io_symErr), 32'd0);
        io_clrErr = 0; io_in_valid = 1; io_in_bits = 12'h003;
        tick("err.push2");
        io_in_valid = 0; io_clrErr = 1;
        tick("err.setwins");
        chk("err.setwins1", 32'(io_symErr), 32'd1);
        io_clrErr = 0;

        // Mid-stream reset with count=3 and valid=1
        do_reset("r5");
        io_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            io_in_valid = 1; io_in_bits = words6[i];
            tick("mid.fill");
        end
        io_in_valid = 0;
        chk("mid.count3", 32'(io_count), 32'd3);
        chk("mid.valid1", 32'(io_valid), 32'd1);
        do_reset("mid.rst");
        io_out_ready = 1;

        // Random traffic against the scoreboard
        for (int r = 0; r < 3; r++) begin
            do_reset("rnd.rst");
            io_postTap = 8'($urandom);
            for (int c = 0; c < 150; c++) begin
                io_in_valid  = 1'($urandom_range(0, 1));
                io_in_bits   = 12'($urandom);
                io_out_ready = ($urandom_range(0, 3) != 0);
                io_clrErr    = ($urandom_range(0, 7) == 0);
                tick("rnd");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pam5_tx_shaper.md
PAM5_TX_SHAPER -- requirements
Module: pam5_tx_shaper

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the input FIFO depth in 12-bit symbol words.
REQ-002 Parameter GAIN, default 32, SHALL set the signed sample amplitude per PAM5 unit level.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port io_in_valid  input  1  SHALL mark io_in_bits as carrying a symbol word.
REQ-006 Port io_in_ready  output  1  SHALL indicate that the FIFO can accept a word.
REQ-007 Port io_in_bits  input  12  SHALL carry packed signed 3-bit symbols: sym0=[11:9], sym1=[8:6], sym2=[5:3], sym3=[2:0].
REQ-008 Port io_postTap  input  8  SHALL carry a signed post-cursor pre-emphasis coefficient, static during operation.
REQ-009 Ports io_samples_0..io_samples_3  output  8 each  SHALL carry signed TX samples for lanes 0..3.
REQ-010 Port io_valid  output  1  SHALL mark io_samples_* as holding a valid word.
REQ-011 Port io_out_ready  input  1  SHALL indicate that the downstream stage consumes the current output word.
REQ-012 Port io_count  output  3  SHALL report the FIFO occupancy, excluding the output register.
REQ-013 Port io_symErr  output  1  SHALL be a sticky flag for an illegal symbol code.
REQ-014 Port io_clrErr  input  1  SHALL clear io_symErr synchronously.

Function
REQ-015 io_in_ready SHALL equal (io_count < DEPTH), computed from registered state only; a push SHALL NOT occur when full, even if a pop happens in the same cycle.
REQ-016 A push SHALL occur on an edge where io_in_valid and io_in_ready are both high; write and read pointers SHALL wrap modulo DEPTH.
REQ-017 The output register SHALL load the FIFO head on an edge where (io_out_ready or not io_valid) and io_count>0, popping the FIFO and setting io_valid=1.
REQ-018 On an edge where io_out_ready=1, io_valid=1 and io_count=0, io_valid SHALL go to 0, samples SHALL hold their values, and lane history SHALL be unchanged.
REQ-019 There SHALL be no bypass: a word pushed at edge N into an empty FIFO SHALL appear with io_valid=1 after edge N+1.
REQ-020 Simultaneous push and pop SHALL leave io_count unchanged.
REQ-021 Legal symbol codes SHALL be -2..+2; codes 3, -3 and -4 SHALL be treated as 0 and set io_symErr at the load edge.
REQ-022 For each lane on load, sample = sym*GAIN + io_postTap*prev, where prev is that lane's previously loaded (sanitized) symbol; then prev SHALL be updated to sym.
REQ-023 Arithmetic SHALL be at least 11-bit signed, and the result SHALL saturate to [-128, 127].
REQ-024 If an error sets and io_clrErr is asserted in the same cycle, set SHALL win.
REQ-025 When io_valid=1 and io_out_ready=0, samples SHALL hold their values.

Reset
REQ-026 While reset is high, the block SHALL asynchronously clear: io_samples_*=0, io_valid=0, io_count=0, io_symErr=0, all pointers=0 and all prev=0.
REQ-027 While reset is high, io_in_ready SHALL be 1; FIFO contents SHALL be discarded.
REQ-028 Operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-029 Reset asserted mid-stream with io_count=3 and io_valid=1 -> io_count=0, io_valid=0, samples=0 and io_in_ready=1 without waiting for a clock edge.
REQ-030 postTap=0, io_out_ready=1, push 0x47E (2,1,-1,-2) at edge N -> after N+1: samples 64,32,-32,-64, io_valid=1; after N+2 with no push: io_valid=0.
REQ-031 postTap=64, push all +2 (0x492) twice back-to-back -> first word: samples 64; second word: 64+128 saturates to 127 on all lanes.
REQ-032 postTap=-16, push all -2 (0xDB6) then all +2 (0x492) -> first word: -64; second word: 64+32=96.
REQ-033 io_out_ready=0, push 6 words -> io_valid=1, io_count reaches 4, io_in_ready=0, extra word dropped; then io_out_ready=1 -> words drain in order, one per cycle.
REQ-034 Push sym0 code 100 (0x800) -> lane0 sample 0, io_symErr=1 and held; pulse io_clrErr -> io_symErr=0 on the next edge.
